// File: rtl/riscv_div_unit_if.sv
// Divide request/response bundle between the EX stage (master) and riscv_div_unit (slave).
interface riscv_div_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_start;
    logic [1:0]      i_op;
    logic [XLEN-1:0] i_dividend;
    logic [XLEN-1:0] i_divisor;
    logic            i_flush;
    logic            o_busy;
    logic            o_done;
    logic [XLEN-1:0] o_result;
    logic            o_stall;

    modport master (
        output i_start, i_op, i_dividend, i_divisor, i_flush,
        input  o_busy, o_done, o_result, o_stall
    );

    modport slave (
        input  i_start, i_op, i_dividend, i_divisor, i_flush,
        output o_busy, o_done, o_result, o_stall
    );
endinterface

// File: rtl/riscv_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: finish at accept when |dividend| < |divisor|.
module riscv_div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    riscv_div_unit_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            is_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, overflow, early;
    logic [XLEN-1:0] special_res;

    // Accept-time decode on the raw request operands.
    always_comb begin
        is_signed = ~bus.i_op[0];
        a_neg     = is_signed & bus.i_dividend[XLEN-1];
        b_neg     = is_signed & bus.i_divisor[XLEN-1];
        a_mag     = a_neg ? -bus.i_dividend : bus.i_dividend;
        b_mag     = b_neg ? -bus.i_divisor : bus.i_divisor;
        div_zero  = (bus.i_divisor == '0);
        overflow  = is_signed && (bus.i_dividend == {1'b1, {(XLEN-1){1'b0}}})
                    && (bus.i_divisor == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = !div_zero && (a_mag < b_mag);
`else
        early     = 1'b0;
`endif
        if (div_zero) begin
            special_res = bus.i_op[1] ? bus.i_dividend : '1;
        end else if (overflow) begin
            special_res = bus.i_op[1] ? '0 : bus.i_dividend;
        end else begin
            special_res = bus.i_op[1] ? bus.i_dividend : '0;
        end
    end

    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] fin_quo, fin_rem, fin_res;

    // rem_q < dvs_q always holds, so the shifted value needs one extra bit only.
    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        ge       = (rem_sh >= {1'b0, dvs_q});
        diff     = rem_sh[XLEN-1:0] - dvs_q;
        step_rem = ge ? diff : rem_sh[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], ge};
        fin_quo  = neg_quo_q ? -step_quo : step_quo;
        fin_rem  = neg_rem_q ? -step_rem : step_rem;
        fin_res  = is_rem_q ? fin_rem : fin_quo;
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start && !bus.i_flush) begin
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    cnt_d     = CNT_W'(XLEN);
                    is_rem_d  = bus.i_op[1];
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (div_zero || overflow || early) begin
                        state_d  = StDone;
                        result_d = special_res;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        state_d = StBusy;
                        busy_d  = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (bus.i_flush) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = StDone;
                        result_d = fin_res;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            StDone: begin
                // A still-high i_start here belongs to the op just finished.
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_result = result_q;
    // Low in DONE so the pipeline advances in the done cycle.
    assign bus.o_stall  = !bus.i_flush &&
                          (((state_q == StIdle) && bus.i_start) || (state_q == StBusy));

endmodule

// File: tb/tb_riscv_div_unit.sv
// Self-checking bench for riscv_div_unit: directed cases plus random ops vs an arithmetic model.
module tb_riscv_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] last_result = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    riscv_div_unit_if #(.XLEN(32)) bus ();

    riscv_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [1:0]  DIR_OP [12] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2,
                                            2'd0, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3};
    localparam logic [31:0] DIR_A  [12] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                            32'd7, 32'd7, 32'd5, 32'd5,
                                            32'h80000000, 32'h80000000, 32'd3, 32'd3};
    localparam logic [31:0] DIR_B  [12] = '{32'd7, 32'd7, 32'd2, 32'd2,
                                            32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0,
                                            32'hFFFFFFFF, 32'hFFFFFFFF, 32'd10, 32'd10};
    localparam logic [31:0] DIR_R  [12] = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                            32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'd5,
                                            32'h80000000, 32'd0, 32'd0, 32'd3};

    // RISC-V semantics via 64-bit integer arithmetic (truncating division).
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0]) begin
            sa = $signed(a);
            sb = $signed(b);
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return op[1] ? 32'(ua % ub) : 32'(ua / ub);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        longint ma, mb;
`endif
        if (b == 0) return 1;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (op[0]) begin
            ma = {32'b0, a};
            mb = {32'b0, b};
        end else begin
            ma = $signed(a);
            mb = $signed(b);
        end
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Drives one op; reports result, cycles from accept to done, stall-high cycles, done time.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output logic [31:0] res, output int lat,
                          output int stalls, output int done_at);
        @(negedge clk);
        bus.i_op       = op;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_start    = 1'b1;
        #1;
        stalls  = int'(bus.o_stall);
        lat     = -1;
        res     = 'x;
        done_at = -1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (bus.o_stall) stalls++;
            if (bus.o_done) begin
                lat     = n;
                res     = bus.o_result;
                done_at = cyc;
                break;
            end
        end
        if (!hold) bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %0b want 0", bus.o_busy);
        end
        vectors++;
        if (bus.o_done !== 1'b0) begin
            miscompares++; $display("FAIL reset_done: got %0b want 0", bus.o_done);
        end
        vectors++;
        if (bus.o_result !== 32'h0) begin
            miscompares++; $display("FAIL reset_result: got %h want 0", bus.o_result);
        end
        vectors++;
        if (bus.o_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_stall: got %0b want 0", bus.o_stall);
        end
        rst = 1'b0;
        last_result = '0;
    endtask

    task automatic test_directed();
        logic [31:0] res;
        int lat, stalls, done_at, exp_lat;
        for (int i = 0; i < 12; i++) begin
            run_op(DIR_OP[i], DIR_A[i], DIR_B[i], 1'b0, res, lat, stalls, done_at);
            exp_lat = ref_latency(DIR_OP[i], DIR_A[i], DIR_B[i]);
            vectors++;
            if (res !== DIR_R[i]) begin
                miscompares++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, DIR_R[i]);
            end
            vectors++;
            if (lat != exp_lat) begin
                miscompares++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, exp_lat);
            end
            vectors++;
            if (stalls != exp_lat) begin
                miscompares++; $display("FAIL directed_stall[%0d]: got %0d want %0d", i, stalls, exp_lat);
            end
            last_result = DIR_R[i];
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, stalls, done_at, dones;
        @(negedge clk);
        bus.i_op = 2'd1; bus.i_dividend = 32'd1000; bus.i_divisor = 32'd3; bus.i_start = 1'b1;
        for (int n = 1; n <= 10; n++) @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++; $display("FAIL flush_busy: got %0b want 0", bus.o_busy);
        end
        vectors++;
        if (bus.o_result !== last_result) begin
            miscompares++; $display("FAIL flush_result: got %h want %h", bus.o_result, last_result);
        end
        bus.i_flush = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++; $display("FAIL flush_no_done: got %0d done pulses want 0", dones);
        end
        run_op(2'd1, 32'd9, 32'd3, 1'b0, res, lat, stalls, done_at);
        vectors++;
        if (res !== 32'd3 || lat != 33) begin
            miscompares++; $display("FAIL flush_next_op: got %0d at cycle %0d want 3 at 33", res, lat);
        end
        last_result = 32'd3;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.i_op = 2'd1; bus.i_dividend = 32'd1000; bus.i_divisor = 32'd7; bus.i_start = 1'b1;
        for (int n = 1; n <= 5; n++) @(negedge clk);
        rst = 1'b1;
        bus.i_start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.o_busy, bus.o_done, bus.o_stall} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_flags: got busy/done/stall %b want 000",
                     {bus.o_busy, bus.o_done, bus.o_stall});
        end
        vectors++;
        if (bus.o_result !== 32'h0) begin
            miscompares++; $display("FAIL midreset_result: got %h want 0", bus.o_result);
        end
        rst = 1'b0;
        last_result = '0;
    endtask

    task automatic test_hold_start();
        logic [31:0] res;
        int lat, stalls, done_at;
        run_op(2'd1, 32'd20, 32'd3, 1'b1, res, lat, stalls, done_at);
        vectors++;
        if (res !== 32'd6 || lat != 33) begin
            miscompares++; $display("FAIL hold_op: got %0d at cycle %0d want 6 at 33", res, lat);
        end
        @(negedge clk);
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_no_reaccept: got busy %0b done %0b want 0 0", bus.o_busy, bus.o_done);
        end
        bus.i_start = 1'b0;
        last_result = 32'd6;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int lat, stalls, d1, d2;
        run_op(2'd1, 32'd20, 32'd4, 1'b0, r1, lat, stalls, d1);
        run_op(2'd1, 32'd21, 32'd4, 1'b0, r2, lat, stalls, d2);
        vectors++;
        if (r1 !== 32'd5 || r2 !== 32'd5) begin
            miscompares++; $display("FAIL b2b_result: got %0d,%0d want 5,5", r1, r2);
        end
        vectors++;
        if (d2 - d1 != 34) begin
            miscompares++; $display("FAIL b2b_spacing: got %0d want 34", d2 - d1);
        end
        last_result = 32'd5;
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        logic [1:0]  op;
        int lat, stalls, done_at, exp_lat;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = $urandom; end
                1: begin
                    a = $urandom_range(0, 1000);
                    b = $urandom_range(1, 50);
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: begin a = $urandom; b = 32'd0; end
                3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                4: begin a = $urandom; b = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFFFFFF; end
                default: begin a = $urandom_range(0, 100); b = $urandom | 32'h100; end
            endcase
            exp     = ref_result(op, a, b);
            exp_lat = ref_latency(op, a, b);
            run_op(op, a, b, 1'b0, res, lat, stalls, done_at);
            vectors++;
            if (res !== exp) begin
                miscompares++;
                $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", op, a, b, res, exp);
            end
            vectors++;
            if (lat != exp_lat) begin
                miscompares++;
                $display("FAIL random_latency op=%0d a=%h b=%h: got %0d want %0d",
                         op, a, b, lat, exp_lat);
            end
            last_result = exp;
        end
    endtask

    initial begin
        bus.i_start    = 1'b0;
        bus.i_op       = 2'd0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        bus.i_flush    = 1'b0;
        test_reset();
        test_directed();
        test_flush();
        test_reset_mid();
        test_hold_start();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_div_unit.md
Name: riscv_div_unit

Overview:
- Iterative multi-cycle divider for the M-extension ops DIV, DIVU, REM and REMU. It sits beside the ALU in the EX stage.
- It is the responder to the pipeline's divide request: the EX stage holds the request, and this unit drives the divide stall back to the hazard logic.
- It returns a registered 32-bit result with a one-cycle done pulse. Branch flushes kill an in-flight operation.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > XLEN.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  EX holds a divide op; held high by EX until o_done.
- i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled on accept.
- i_dividend  input  XLEN  rs1 value; sampled on accept.
- i_divisor  input  XLEN  rs2 value; sampled on accept.
- i_flush  input  1  branch flush; kills the current op.
- o_busy  output  1  registered; high while in BUSY.
- o_done  output  1  registered; one-cycle pulse, result valid.
- o_result  output  XLEN  registered quotient/remainder; held until the next accept.
- o_stall  output  1  combinational, drives stall_div.

Behaviour:
- Reset: state=IDLE; o_busy=0, o_done=0, o_result=0; counter and working registers cleared.
- Reset has priority over all inputs in any state, including mid-operation. No o_done is produced for an aborted op.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept when i_start=1 and i_flush=0; the accept cycle is cycle 0.
  - Operands and op are latched on that edge.
  - If the special case detected at accept (see below) is divide-by-zero or overflow, go to DONE. Otherwise go to BUSY with counter=XLEN.
- BUSY:
  - One restoring-division step per cycle on absolute values.
  - Shift the {rem,quo} pair left by 1, trial-subtract the divisor magnitude, and set quotient bit on non-negative.
  - The counter decrements; on the step where the counter reaches 0, go to DONE.
  - Normal latency: BUSY during cycles 1..XLEN, DONE in cycle XLEN+1.
- DONE:
  - o_done=1 for exactly one cycle; o_result is written on entry to DONE.
  - Next state is IDLE unconditionally. i_start still high in DONE is the same instruction and is never accepted.
- i_flush in BUSY or DONE: next state IDLE, o_busy=0, o_done=0, o_result unchanged.
- i_flush in IDLE beats i_start; no accept occurs.
- o_stall = i_flush ? 0 : ((IDLE & i_start) | BUSY). It is low in DONE, so the pipeline advances in the done cycle.
- Signed ops (DIV, REM):
  - Divide magnitudes.
  - Negate the quotient when the operand signs differ.
  - The remainder takes the dividend's sign.
  - Identity: dividend = quotient*divisor + remainder.
- Divide-by-zero (divisor=0), detected at accept:
  - DIV/DIVU result = all ones.
  - REM/REMU result = dividend.
  - Latency: DONE in cycle 1.
- Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF):
  - DIV result = 0x80000000.
  - REM result = 0.
  - Latency: DONE in cycle 1.
- Back-to-back divides: the new op is accepted in the IDLE cycle after DONE.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: at accept, if |dividend| < |divisor| (unsigned compare of magnitudes, divisor nonzero), BUSY is skipped and the result is available in cycle 1.
  - DIV/DIVU give 0.
  - REM/REMU give the original dividend.
  - The divide-by-zero and overflow cases take priority.
- Undefined: all non-special ops take the full XLEN+1 cycle latency.

Test Plan:
- DIVU 100/7, i_start held: o_stall=1 in cycles 0..32, o_done=1 in cycle 33 with o_result=14; REMU on the same operands gives 2.
- DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIV 7/-2 gives 0xFFFFFFFD; REM 7/-2 gives 1.
- DIV 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5, each with o_done in cycle 1; DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0, each in cycle 1.
- i_flush in cycle 10 of DIVU 1000/3: o_busy=0 next cycle, no o_done, o_result keeps its old value; a following DIVU 9/3 gives 3 in cycle 33.
- rst in cycle 5 of an op: all outputs are 0 the next cycle; i_start held across DONE gives no second accept; two back-to-back DIVU ops (20/4, then 21/4) give 5 and then 5, done cycles 34 apart.
- With DIV_EARLY_OUT_EN: DIVU 3/10 gives o_result=0 in cycle 1 and REMU 3/10 gives 3 in cycle 1; without the macro, both complete in cycle 33.
